// File: rtl/perceptron.sv
// Four-input perceptron behind a UART (8N1) command interface: receiver, one-byte holding register,
// command parser with a serial MAC evaluator, and transmitter. Define PERCEPTRON_TRAIN_EN for command 0xAC.
module perceptron #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic nRst,
  input  logic rx,
  output logic tx
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {P_CMD, P_ADDR, P_DATA, P_EXEC, P_SEND} p_state_t;

  // ---------------- receiver ----------------
  rx_state_t rx_state, rx_next;
  logic          rx_meta, rx_sync, rx_prev;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift, rx_data;
  logic          rx_done, rx_tick;

  assign rx_tick = (rx_state == RX_START) ? (rx_cnt == HALF_M1) : (rx_cnt == FULL_M1);

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_prev && !rx_sync) rx_next = RX_START;
      RX_START: if (rx_tick) rx_next = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (rx_tick) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  // A byte whose stop bit samples low simply returns to IDLE without raising rx_done.
  always_ff @(posedge clk) begin
    if (nRst) begin
      rx_state <= RX_IDLE;
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_prev  <= 1'b1;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      rx_done  <= 1'b0;
    end else begin
      rx_meta  <= rx;
      rx_sync  <= rx_meta;
      rx_prev  <= rx_sync;
      rx_state <= rx_next;
      rx_done  <= 1'b0;
      if (rx_state == RX_IDLE || rx_tick) rx_cnt <= '0;
      else                                rx_cnt <= rx_cnt + CW'(1);
      if (rx_state == RX_START) rx_bit <= '0;
      if (rx_state == RX_DATA && rx_tick) begin
        rx_shift <= {rx_sync, rx_shift[7:1]};
        rx_bit   <= rx_bit + 3'd1;
      end
      if (rx_state == RX_STOP && rx_tick && rx_sync) begin
        rx_done <= 1'b1;
        rx_data <= rx_shift;
      end
    end
  end

  // ---------------- holding register ----------------
  p_state_t   p_state, p_next;
  logic       hold_valid, hold_take;
  logic [7:0] hold_data;

  assign hold_take = hold_valid && (p_state == P_CMD || p_state == P_ADDR || p_state == P_DATA);

  always_ff @(posedge clk) begin
    if (nRst) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else begin
      if (hold_take) hold_valid <= 1'b0;
      if (rx_done && (!hold_valid || hold_take)) begin
        hold_valid <= 1'b1;
        hold_data  <= rx_data;
      end
    end
  end

  // ---------------- registers and MAC ----------------
  logic signed [7:0]  w [4];
  logic signed [7:0]  x [4];
  logic signed [7:0]  b;
  logic [7:0]         cmd, addr, reply, rd_data;
  logic [1:0]         mac_idx;
  logic signed [15:0] prod;
  logic signed [18:0] acc, acc_sum;
  logic               y;
  logic               tx_busy, tx_start;

  assign prod    = 16'(w[mac_idx]) * 16'(x[mac_idx]);
  assign acc_sum = acc + 19'(prod);
  assign y       = !acc_sum[18] && (acc_sum != '0);

  always_comb begin
    rd_data = 8'h00;
    if (hold_data[7:2] == 6'b000000)      rd_data = w[hold_data[1:0]];
    else if (hold_data == 8'h04)          rd_data = b;
    else if (hold_data[7:2] == 6'b000100) rd_data = x[hold_data[1:0]];
  end

`ifdef PERCEPTRON_TRAIN_EN
  logic target;

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] d, input logic sub);
    logic [8:0] s;
    s = sub ? ({a[7], a} - {d[7], d}) : ({a[7], a} + {d[7], d});
    if (s[8] != s[7]) return s[8] ? 8'h80 : 8'h7F;
    return s[7:0];
  endfunction
`endif

  // ---------------- parser ----------------
  always_comb begin
    p_next = p_state;
    case (p_state)
      P_CMD: if (hold_valid) begin
        case (hold_data)
          8'hAA:        p_next = P_SEND;
          8'hAD, 8'hAB: p_next = P_ADDR;
          8'hAE:        p_next = P_EXEC;
`ifdef PERCEPTRON_TRAIN_EN
          8'hAC:        p_next = P_DATA;
`endif
          default:      p_next = P_CMD;
        endcase
      end
      P_ADDR: if (hold_valid) p_next = (cmd == 8'hAD) ? P_DATA : P_SEND;
`ifdef PERCEPTRON_TRAIN_EN
      P_DATA: if (hold_valid) p_next = (cmd == 8'hAD) ? P_CMD : P_EXEC;
`else
      P_DATA: if (hold_valid) p_next = P_CMD;
`endif
      P_EXEC: if (mac_idx == 2'd3) p_next = P_SEND;
      P_SEND: if (!tx_busy) p_next = P_CMD;
      default: p_next = P_CMD;
    endcase
  end

  assign tx_start = (p_state == P_SEND) && !tx_busy;

  // The accumulator is seeded with the bias on every command byte so EXEC only has to add products.
  always_ff @(posedge clk) begin
    if (nRst) begin
      p_state <= P_CMD;
      cmd     <= '0;
      addr    <= '0;
      reply   <= '0;
      acc     <= '0;
      mac_idx <= '0;
      b       <= '0;
      for (int i = 0; i < 4; i++) begin
        w[i] <= '0;
        x[i] <= '0;
      end
`ifdef PERCEPTRON_TRAIN_EN
      target  <= 1'b0;
`endif
    end else begin
      p_state <= p_next;
      case (p_state)
        P_CMD: if (hold_valid) begin
          cmd     <= hold_data;
          reply   <= 8'h55;
          acc     <= 19'(b);
          mac_idx <= '0;
        end
        P_ADDR: if (hold_valid) begin
          addr  <= hold_data;
          reply <= rd_data;
        end
        P_DATA: if (hold_valid) begin
          if (cmd == 8'hAD) begin
            if (addr[7:2] == 6'b000000)      w[addr[1:0]] <= hold_data;
            else if (addr == 8'h04)          b <= hold_data;
            else if (addr[7:2] == 6'b000100) x[addr[1:0]] <= hold_data;
          end
`ifdef PERCEPTRON_TRAIN_EN
          target <= hold_data[0];
`endif
        end
        P_EXEC: begin
          acc     <= acc_sum;
          mac_idx <= mac_idx + 2'd1;
          if (mac_idx == 2'd3) begin
            reply <= {7'b0, y};
`ifdef PERCEPTRON_TRAIN_EN
            if (cmd == 8'hAC && y != target) begin
              for (int i = 0; i < 4; i++) w[i] <= sat_add(w[i], x[i], !target);
              b <= sat_add(b, 8'h01, !target);
            end
`endif
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- transmitter ----------------
  tx_state_t     tx_state, tx_next;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift;
  logic          tx_tick;

  assign tx_tick = (tx_cnt == FULL_M1);
  assign tx_busy = (tx_state != TX_IDLE);

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE:  if (tx_start) tx_next = TX_START;
      TX_START: if (tx_tick) tx_next = TX_DATA;
      TX_DATA:  if (tx_tick && tx_bit == 3'd7) tx_next = TX_STOP;
      TX_STOP:  if (tx_tick) tx_next = TX_IDLE;
      default:  tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (nRst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx       <= 1'b1;
    end else begin
      tx_state <= tx_next;
      if (tx_state == TX_IDLE || tx_tick) tx_cnt <= '0;
      else                                tx_cnt <= tx_cnt + CW'(1);
      case (tx_state)
        TX_IDLE: if (tx_start) begin
          tx       <= 1'b0;
          tx_shift <= reply;
          tx_bit   <= '0;
        end
        TX_START: if (tx_tick) tx <= tx_shift[0];
        TX_DATA: if (tx_tick) begin
          tx       <= (tx_bit == 3'd7) ? 1'b1 : tx_shift[1];
          tx_shift <= {1'b0, tx_shift[7:1]};
          tx_bit   <= tx_bit + 3'd1;
        end
        default: tx <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_perceptron.sv
// Bench for perceptron: drives UART command frames, decodes tx replies and checks them against a
// register-level model of the command set (plus hand-computed literals that pin the model).
`timescale 1ns/1ps
module tb_perceptron;
  localparam int BIT = 16;

  logic clk = 1'b0;
  logic nRst = 1'b1;
  logic rx = 1'b1;
  logic tx;

  perceptron #(.CLKS_PER_BIT(BIT)) dut (.clk(clk), .nRst(nRst), .rx(rx), .tx(tx));

  always #10 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int stop_cyc = 0;

  always @(posedge clk) cyc++;

  typedef struct {
    string name;
    int    val;
    int    lit;
  } exp_t;
  exp_t exp_q[$];

  int mw[4], mx[4], mb;

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic int s8(input logic [7:0] v);
    return int'($signed(v));
  endfunction

  function automatic int sat8(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  function automatic int m_read(input int a);
    if (a < 4) return mw[a] & 255;
    if (a == 4) return mb & 255;
    if (a >= 16 && a < 20) return mx[a-16] & 255;
    return 0;
  endfunction

  function automatic int m_eval();
    int s = mb;
    for (int i = 0; i < 4; i++) s += mw[i] * mx[i];
    return (s > 0) ? 1 : 0;
  endfunction

  function automatic int m_train(input int t);
    int yy = m_eval();
    if (yy != t) begin
      for (int i = 0; i < 4; i++) mw[i] = sat8(t ? mw[i] + mx[i] : mw[i] - mx[i]);
      mb = sat8(t ? mb + 1 : mb - 1);
    end
    return yy;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 4; i++) begin
      mw[i] = 0;
      mx[i] = 0;
    end
    mb = 0;
  endfunction

  // Reply decoder and compare process: samples tx at bit centres on the falling clock edge.
  int         mcnt, mk;
  logic       mbusy = 1'b0;
  logic [7:0] mshift;
  exp_t       e;

  always @(negedge clk) begin
    if (nRst) begin
      mbusy = 1'b0;
    end else if (!mbusy) begin
      if (tx == 1'b0) begin
        mbusy = 1'b1;
        mcnt  = 0;
        checkOutput("reply_latency_ok", (cyc - stop_cyc <= BIT/2 + 11) ? 1 : 0, 1);
      end
    end else begin
      mcnt++;
      if (mcnt % BIT == BIT/2) begin
        mk = mcnt / BIT;
        if (mk == 0) begin
          if (tx !== 1'b0) begin
            checkOutput("start_bit", int'(tx), 0);
            mbusy = 1'b0;
          end
        end else if (mk <= 8) begin
          mshift[mk-1] = tx;
        end else begin
          mbusy = 1'b0;
          checkOutput("stop_bit", int'(tx), 1);
          if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL extra_reply: got 0x%0h, expected no reply", mshift);
          end else begin
            e = exp_q.pop_front();
            checkOutput(e.name, int'(mshift), e.val);
            if (e.lit >= 0) checkOutput({e.name, "_model"}, e.val, e.lit);
          end
        end
      end
    end
  end

  task automatic sendByte(input logic [7:0] d, input logic stopb);
    @(posedge clk); #1;
    rx = 1'b0;
    repeat (BIT) @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (BIT) @(posedge clk); #1;
    end
    rx = stopb;
    stop_cyc = cyc;
    repeat (BIT) @(posedge clk); #1;
    rx = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic applyStimulus(input logic [7:0] d);
    sendByte(d, 1'b1);
  endtask

  task automatic expectReply(input string name, input int val, input int lit);
    exp_t n;
    n.name = name;
    n.val  = val;
    n.lit  = lit;
    exp_q.push_back(n);
  endtask

  task automatic waitReplies();
    int n = 0;
    while ((exp_q.size() != 0 || mbusy) && n < 30 * BIT) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL reply_timeout: %0d replies outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2 * BIT) @(posedge clk);
  endtask

  task automatic writeReg(input logic [7:0] a, input logic [7:0] d);
    applyStimulus(8'hAD);
    applyStimulus(a);
    applyStimulus(d);
    if (a < 4) mw[a] = s8(d);
    else if (a == 4) mb = s8(d);
    else if (a >= 16 && a < 20) mx[a-16] = s8(d);
  endtask

  task automatic readReg(input string name, input logic [7:0] a, input int lit);
    applyStimulus(8'hAB);
    expectReply(name, m_read(int'(a)), lit);
    applyStimulus(a);
    waitReplies();
  endtask

  task automatic evaluate(input string name, input int lit);
    expectReply(name, m_eval(), lit);
    applyStimulus(8'hAE);
    waitReplies();
  endtask

  task automatic ping(input string name);
    expectReply(name, 8'h55, 8'h55);
    applyStimulus(8'hAA);
    waitReplies();
  endtask

  initial begin
    #4_000_000;
    $display("[TB] FAIL watchdog: simulation still running, expected to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
`ifdef PERCEPTRON_TRAIN_EN
    int yy;
`endif
    m_reset();
    repeat (3) @(posedge clk); #1;
    checkOutput("reset_tx", int'(tx), 1);
    nRst = 1'b0;
    repeat (4) @(posedge clk);

    for (int i = 0; i < 5; i++) begin
      expectReply("ping_burst", 8'h55, 8'h55);
      applyStimulus(8'hAA);
      repeat (3 * BIT) @(posedge clk);
    end
    waitReplies();

    readReg("reset_b", 8'h04, 0);
    readReg("reset_x0", 8'h10, 0);

    writeReg(8'h01, 8'h00);
    readReg("w1_zero", 8'h01, 8'h00);
    writeReg(8'h01, 8'h7F);
    readReg("w1_7f", 8'h01, 8'h7F);

    writeReg(8'h20, 8'h55);
    readReg("unmapped_20", 8'h20, 0);
    readReg("unmapped_05", 8'h05, 0);

    writeReg(8'h00, 8'h02);
    writeReg(8'h10, 8'h03);
    writeReg(8'h04, 8'hF9);
    evaluate("eval_sm1", 0);
    writeReg(8'h04, 8'hFA);
    evaluate("eval_s0", 0);
    writeReg(8'h04, 8'hFB);
    evaluate("eval_s1", 1);

    writeReg(8'h03, 8'h80);
    writeReg(8'h13, 8'h7F);
    readReg("x3_7f", 8'h13, 8'h7F);
    evaluate("eval_big_neg", 0);
    writeReg(8'h02, 8'h80);
    writeReg(8'h12, 8'h80);
    evaluate("eval_big_mix", 1);

    applyStimulus(8'h77);
    ping("ping_after_unknown");

    sendByte(8'h3C, 1'b0);
    ping("ping_after_framing");
    repeat (12 * BIT) @(posedge clk);

    expectReply("ping_aborted", 8'h55, -1);
    applyStimulus(8'hAA);
    n = 0;
    while (!mbusy && n < 60) begin
      @(posedge clk);
      n++;
    end
    checkOutput("reply_started", int'(mbusy), 1);
    repeat (2 * BIT + BIT/2) @(negedge clk);
    checkOutput("tx_mid_reply_low", int'(tx), 0);
    nRst = 1'b1;
    @(posedge clk); #1;
    checkOutput("tx_after_reset", int'(tx), 1);
    exp_q.delete();
    m_reset();
    repeat (2) @(posedge clk);
    nRst = 1'b0;
    repeat (4) @(posedge clk);
    readReg("w0_after_reset", 8'h00, 0);

`ifdef PERCEPTRON_TRAIN_EN
    writeReg(8'h00, 8'h7E);
    writeReg(8'h10, 8'h05);
    writeReg(8'h01, 8'h80);
    writeReg(8'h11, 8'h05);
    writeReg(8'h04, 8'h80);
    applyStimulus(8'hAC);
    yy = m_train(1);
    expectReply("train_t1", yy, 0);
    applyStimulus(8'h01);
    waitReplies();
    readReg("train_w0_sat", 8'h00, 8'h7F);
    readReg("train_b", 8'h04, 8'h81);
    readReg("train_w1", 8'h01, 8'h85);
    applyStimulus(8'hAC);
    yy = m_train(0);
    expectReply("train_t0", yy, 0);
    applyStimulus(8'h00);
    waitReplies();
    readReg("train_w0_kept", 8'h00, 8'h7F);
`else
    writeReg(8'h00, 8'h11);
    applyStimulus(8'hAC);
    applyStimulus(8'h01);
    ping("ping_after_ac");
    readReg("w0_after_ac", 8'h00, 8'h11);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
